ysyx_22041207_div: RTL and testbench

Multi-cycle iterative radix-2 divider serving the ALU's DIV/DIVU/REM/REMU and word-form operations. It takes the ALU's selected operands `a`/`b` through the same valid/flush/ready/out_valid handshake the ALU uses for its multiplier. It returns quotient and remainder together, and the ALU holds `alu_wait` until `out_valid`. It replaces the ALU's single-cycle `/` and `%` operators.

---
 rtl/ysyx_22041207_div_if.sv | 33 +++
 rtl/ysyx_22041207_div.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_22041207_div.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_div_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : ysyx_22041207_div_if                                             |
// | Brief    : Request/response bundle between the ALU and the iterative divider |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface ysyx_22041207_div_if #(
  parameter int XLEN = 64
);
  logic            div_valid;
  logic            flush;
  logic            div_signed;
  logic            divw;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output div_valid, flush, div_signed, divw, dividend, divisor,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, flush, div_signed, divw, dividend, divisor,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22041207_div.sv
// +-----------------------------------------------------------------------------+
// | Module   : ysyx_22041207_div                                                |
// | Brief    : Radix-2 restoring divider, signed/unsigned, 64-bit and word mode. |
// |            Optional YSYX_22041207_DIV_EARLY_OUT_EN skips iterations when the |
// |            result is trivial.                                                |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ysyx_22041207_div #(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22041207_div_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              divw_q, divw_d;
  logic [XLEN-1:0]   quotient_q, quotient_d;
  logic [XLEN-1:0]   remainder_q, remainder_d;
  logic              out_valid_q, out_valid_d;

  logic              div_ready;
  logic              accept;
  logic [XLEN-1:0]   ext_a, ext_b, abs_a, abs_b, dvd_init;
  logic              sign_a, sign_b;
  logic              take_early;
  logic [XLEN:0]     shifted;
  logic              step_ge;
  logic [XLEN:0]     step_diff;
  logic              last_iter;
  logic [XLEN-1:0]   q_raw, q_fix, r_fix, q_out, r_out;

  // Ready stays low through the result pulse so a new op can't overlap it.
  assign div_ready = (state_q == S_IDLE) && !out_valid_q;
  assign accept    = bus.div_valid && div_ready && !bus.flush;

  // Word operands are widened first so one abs/sign path serves both modes.
  always_comb begin
    ext_a = bus.dividend;
    ext_b = bus.divisor;
    if (bus.divw) begin
      ext_a = {{(XLEN-32){bus.div_signed & bus.dividend[31]}}, bus.dividend[31:0]};
      ext_b = {{(XLEN-32){bus.div_signed & bus.divisor[31]}},  bus.divisor[31:0]};
    end
  end

  assign sign_a   = bus.div_signed & ext_a[XLEN-1];
  assign sign_b   = bus.div_signed & ext_b[XLEN-1];
  assign abs_a    = sign_a ? -ext_a : ext_a;
  assign abs_b    = sign_b ? -ext_b : ext_b;
  // Word dividend sits at the top so 32 shifts drain it and leave the quotient in [31:0].
  assign dvd_init = bus.divw ? (abs_a << (XLEN-32)) : abs_a;

`ifdef YSYX_22041207_DIV_EARLY_OUT_EN
  assign take_early = (abs_b == '0) || (abs_b > abs_a);
`else
  assign take_early = 1'b0;
`endif

  assign shifted   = {rem_q, dvd_q[XLEN-1]};
  assign step_diff = shifted - {1'b0, dsr_q};
  assign step_ge   = (shifted >= {1'b0, dsr_q});
  assign last_iter = (cnt_q == (divw_q ? CNT_W'(31) : CNT_W'(XLEN-1)));

  always_comb begin
    q_raw = divw_q ? {{(XLEN-32){1'b0}}, dvd_q[31:0]} : dvd_q;
    q_fix = (q_neg_q && (dsr_q != '0)) ? -q_raw : q_raw;
    r_fix = r_neg_q ? -rem_q : rem_q;
    q_out = divw_q ? {{(XLEN-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
    r_out = divw_q ? {{(XLEN-32){r_fix[31]}}, r_fix[31:0]} : r_fix;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    divw_d      = divw_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          dsr_d   = abs_b;
          q_neg_d = sign_a ^ sign_b;
          r_neg_d = sign_a;
          divw_d  = bus.divw;
          if (take_early) begin
            rem_d   = abs_a;
            dvd_d   = (abs_b == '0) ? '1 : '0;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = dvd_init;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = step_ge ? step_diff[XLEN-1:0] : shifted[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], step_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        quotient_d  = q_out;
        remainder_d = r_out;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      divw_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      divw_q      <= divw_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.div_ready = div_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041207_div.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_ysyx_22041207_div                                             |
// | Brief    : Directed and randomized checks of the divider against a model.    |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22041207_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22041207_div_if #(.XLEN(64)) bus ();
  ysyx_22041207_div #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        w;
    logic [63:0] q;
    logic [63:0] r;
  } vec_t;

  int          checks = 0;
  int          passes = 0;
  logic [63:0] q_got, r_got, q_exp, r_exp;
  int          lat;
  vec_t        dir_vecs [9];

  // Reference: plain arithmetic plus the architectural special cases.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0;
      end else if (s) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    bit ready_seen;
    ready_seen = 1'b0;
    @(negedge clk);
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_signed = s;
    bus.divw       = w;
    bus.div_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.div_ready === 1'b1) begin
        ready_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ready_seen) begin
      checks++;
      $display("FAIL issue_ready: div_ready=%b required=1", bus.div_ready);
    end
    @(posedge clk);
    #1 bus.div_valid = 1'b0;
  endtask

  task automatic collect(output logic [63:0] q, output logic [63:0] r, output int cycles);
    cycles = -1;
    q = 'x;
    r = 'x;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        cycles = k;
        q = bus.quotient;
        r = bus.remainder;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.div_valid = 1'b0; bus.flush = 1'b0; bus.div_signed = 1'b0; bus.divw = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL reset_ready: got=%b required=1", bus.div_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got=%b required=0", bus.out_valid); else passes++;
    checks++; if (bus.quotient !== 64'd0) $display("FAIL reset_quot: got=%h required=0", bus.quotient); else passes++;
    checks++; if (bus.remainder !== 64'd0) $display("FAIL reset_rem: got=%h required=0", bus.remainder); else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    int exp_lat;
    dir_vecs = '{
      '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2},
      '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF},
      '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1},
      '{64'd5, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5},
      '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0},
      '{64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0},
      '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0},
      '{64'hFFFF_FFFF_0000_0007, 64'h1234_5678_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7},
      '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}
    };
    foreach (dir_vecs[i]) begin
      exp_lat = dir_vecs[i].w ? 33 : 65;
      issue(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].s, dir_vecs[i].w);
      collect(q_got, r_got, lat);
      checks++; if (lat !== exp_lat) $display("FAIL dir%0d_latency: got=%0d required=%0d", i, lat, exp_lat); else passes++;
      checks++; if (q_got !== dir_vecs[i].q) $display("FAIL dir%0d_quot: got=%h required=%h", i, q_got, dir_vecs[i].q); else passes++;
      checks++; if (r_got !== dir_vecs[i].r) $display("FAIL dir%0d_rem: got=%h required=%h", i, r_got, dir_vecs[i].r); else passes++;
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL dir%0d_pulse_width: out_valid=%b required=0", i, bus.out_valid); else passes++;
      checks++; if (bus.div_ready !== 1'b1) $display("FAIL dir%0d_ready_after: got=%b required=1", i, bus.div_ready); else passes++;
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b;
    logic        s, w;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(1, 300));
        2: b = -64'($urandom_range(1, 300));
        3: b = 64'd0;
        default: b = {32'd0, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(0, 50));
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      ref_div(a, b, s, w, q_exp, r_exp);
      issue(a, b, s, w);
      collect(q_got, r_got, lat);
      checks++; if (lat !== (w ? 33 : 65)) $display("FAIL rnd%0d_latency: got=%0d required=%0d", n, lat, w ? 33 : 65); else passes++;
      checks++; if (q_got !== q_exp) $display("FAIL rnd%0d_quot: a=%h b=%h s=%b w=%b got=%h required=%h", n, a, b, s, w, q_got, q_exp); else passes++;
      checks++; if (r_got !== r_exp) $display("FAIL rnd%0d_rem: a=%h b=%h s=%b w=%b got=%h required=%h", n, a, b, s, w, r_got, r_exp); else passes++;
    end
  endtask

  task automatic test_flush;
    int pulses;
    issue(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got=%b required=0", bus.out_valid); else passes++;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL flush_ready: got=%b required=1", bus.div_ready); else passes++;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (bus.out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL flush_no_result: pulses=%0d required=0", pulses); else passes++;
    // flush together with a request must not start an operation
    bus.dividend = 64'd50; bus.divisor = 64'd5; bus.div_signed = 1'b0; bus.divw = 1'b0;
    bus.div_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1 begin bus.div_valid = 1'b0; bus.flush = 1'b0; end
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL flush_blocks_accept: ready=%b required=1", bus.div_ready); else passes++;
    issue(64'd81, 64'd9, 1'b0, 1'b0);
    collect(q_got, r_got, lat);
    checks++; if (lat !== 65) $display("FAIL post_flush_latency: got=%0d required=65", lat); else passes++;
    checks++; if (q_got !== 64'd9) $display("FAIL post_flush_quot: got=%h required=9", q_got); else passes++;
    checks++; if (r_got !== 64'd0) $display("FAIL post_flush_rem: got=%h required=0", r_got); else passes++;
  endtask

  task automatic test_reset_mid;
    int pulses;
    issue(64'd12345, 64'd10, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.quotient !== 64'd0) $display("FAIL rstmid_quot: got=%h required=0", bus.quotient); else passes++;
    checks++; if (bus.remainder !== 64'd0) $display("FAIL rstmid_rem: got=%h required=0", bus.remainder); else passes++;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL rstmid_ready: got=%b required=1", bus.div_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid: got=%b required=0", bus.out_valid); else passes++;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (bus.out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL rstmid_no_result: pulses=%0d required=0", pulses); else passes++;
  endtask

  task automatic test_back_to_back;
    issue(64'd1000, 64'd33, 1'b0, 1'b0);
    collect(q_got, r_got, lat);
    checks++; if (q_got !== 64'd30 || r_got !== 64'd10) $display("FAIL b2b_first: got=%h/%h required=1e/a", q_got, r_got); else passes++;
    bus.dividend = 64'hFFFF_FFFF_FFFF_FF9C; bus.divisor = 64'd8;
    bus.div_signed = 1'b1; bus.divw = 1'b0; bus.div_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL b2b_ready: got=%b required=1", bus.div_ready); else passes++;
    @(posedge clk);
    #1 bus.div_valid = 1'b0;
    checks++; if (bus.div_ready !== 1'b0) $display("FAIL b2b_accept: ready=%b required=0", bus.div_ready); else passes++;
    collect(q_got, r_got, lat);
    checks++; if (lat !== 65) $display("FAIL b2b_latency: got=%0d required=65", lat); else passes++;
    checks++; if (q_got !== 64'hFFFF_FFFF_FFFF_FFF4) $display("FAIL b2b_quot: got=%h required=fffffffffffffff4", q_got); else passes++;
    checks++; if (r_got !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL b2b_rem: got=%h required=fffffffffffffffc", r_got); else passes++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
